// File: rtl/tx_pi_ramp_ctl.sv
// Ramps the four TX phase-interpolator control words toward a target set in
// bounded steps, strobing ctl_valid after each code change and dwelling between steps.
module tx_pi_ramp_ctl #(
  parameter int Npi       = 9,
  parameter int Nout      = 4,
  parameter int Ndwell    = 8,
  parameter int VALID_CYC = 2,
  parameter int INIT_CODE = 0
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic                 abort,
  input  logic [Nout*Npi-1:0]  tgt_pi,
  input  logic [Npi-1:0]       step,
  input  logic [Ndwell-1:0]    dwell,
  output logic [Nout*Npi-1:0]  ctl_pi,
  output logic                 ctl_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int VW = (VALID_CYC > 1) ? $clog2(VALID_CYC) : 1;
  localparam logic [Nout*Npi-1:0] INIT_ALL = {Nout{Npi'(INIT_CODE)}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_SETTLE,
    S_STROBE,
    S_DWELL,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                state, next_state;
  logic [Nout*Npi-1:0]   tgt_q;
  logic [Nout*Npi-1:0]   pi_next;
  logic [Npi-1:0]        step_q;
  logic [VW-1:0]         vcnt;
  logic [Ndwell-1:0]     dcnt;
  logic                  accept;

  // Unsigned codes are compared through an Npi+1-bit difference so a lane never
  // wraps past 0 or full scale and lands exactly on target when within one step.
  function automatic logic [Npi-1:0] move_lane(input logic [Npi-1:0] cur,
                                               input logic [Npi-1:0] tgt,
                                               input logic [Npi-1:0] stp);
    logic [Npi:0] diff;
    logic [Npi:0] mag;
    diff = {1'b0, tgt} - {1'b0, cur};
    mag  = diff[Npi] ? ((Npi+1)'(0) - diff) : diff;
    if (mag <= {1'b0, stp})
      move_lane = tgt;
    else if (diff[Npi])
      move_lane = cur - stp;
    else
      move_lane = cur + stp;
  endfunction

  always_comb begin
    pi_next = ctl_pi;
    for (int k = 0; k < Nout; k++)
      pi_next[k*Npi +: Npi] = move_lane(ctl_pi[k*Npi +: Npi], tgt_q[k*Npi +: Npi], step_q);
  end

  assign accept = (state == S_IDLE) && start && !abort;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (accept) next_state = (tgt_pi == ctl_pi) ? S_DONE : S_UPDATE;
      S_UPDATE: next_state = S_SETTLE;
      S_SETTLE: next_state = S_STROBE;
      S_STROBE: if (vcnt == '0) next_state = (dwell == '0) ? S_CHECK : S_DWELL;
      S_DWELL:  if (dcnt == '0) next_state = S_CHECK;
      S_CHECK:  next_state = (tgt_q == ctl_pi) ? S_DONE : S_UPDATE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && state != S_IDLE)
      next_state = S_IDLE;
  end

  // Status outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      ctl_pi    <= INIT_ALL;
      tgt_q     <= INIT_ALL;
      step_q    <= '0;
      vcnt      <= '0;
      dcnt      <= '0;
      ctl_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      ctl_valid <= (next_state == S_STROBE);
      busy      <= (next_state != S_IDLE);
      done      <= (next_state == S_DONE);

      if (accept) begin
        tgt_q  <= tgt_pi;
        step_q <= (step == '0) ? Npi'(1) : step;
      end

      if (state == S_UPDATE && !abort)
        ctl_pi <= pi_next;

      if (state == S_SETTLE)
        vcnt <= VW'(VALID_CYC - 1);
      else if (state == S_STROBE && vcnt != '0)
        vcnt <= vcnt - VW'(1);

      if (state == S_STROBE && vcnt == '0 && dwell != '0)
        dcnt <= dwell - Ndwell'(1);
      else if (state == S_DWELL && dcnt != '0)
        dcnt <= dcnt - Ndwell'(1);
    end
  end

endmodule

// File: tb/tb_tx_pi_ramp_ctl.sv
// Bench for tx_pi_ramp_ctl: cycle table for the basic handshake, directed corner
// sequences, and randomized ramps checked against an arithmetic step model.
module tb_tx_pi_ramp_ctl;

  localparam int NPI  = 9;
  localparam int NOUT = 4;
  localparam int VC   = 2;

  logic              clk = 1'b0;
  logic              rstb;
  logic              start;
  logic              abort;
  logic [NOUT*NPI-1:0] tgt_pi;
  logic [NPI-1:0]    step;
  logic [7:0]        dwell;
  logic [NOUT*NPI-1:0] ctl_pi;
  logic              ctl_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [NOUT*NPI-1:0] model_pi;

  typedef struct {
    logic        start;
    logic        abort;
    logic [35:0] tgt;
    logic [8:0]  step;
    logic [7:0]  dwell;
    logic [35:0] exp_pi;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[10];

  tx_pi_ramp_ctl #(
    .Npi(NPI), .Nout(NOUT), .Ndwell(8), .VALID_CYC(VC), .INIT_CODE(0)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .tgt_pi(tgt_pi),
    .step(step), .dwell(dwell), .ctl_pi(ctl_pi), .ctl_valid(ctl_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  function automatic int lane(input logic [35:0] v, input int k);
    return int'(v[k*9 +: 9]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [35:0] t,
                               input logic [8:0] st, input logic [7:0] dw);
    start  = s;
    abort  = a;
    tgt_pi = t;
    step   = st;
    dwell  = dw;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    model_pi = '0;
  endtask

  // Starts a ramp from the current model codes, watches it to completion and
  // compares strobe contents, timing, done pulse and final codes with the model.
  task automatic runRamp(input logic [35:0] tv, input int s, input int d,
                         input bit repulse_in, input string tag);
    int cur[4];
    int tg[4];
    int lo[4];
    int hi[4];
    logic [35:0] exp_q[$];
    int n, period, seff, rises, vcycles, dones, done_cyc, idle_cyc, diff, v;
    bit prev_v, range_ok, ended, repulse;
    seff = (s == 0) ? 1 : s;
    for (int k = 0; k < 4; k++) begin
      cur[k] = lane(model_pi, k);
      tg[k]  = lane(tv, k);
      lo[k]  = (cur[k] < tg[k]) ? cur[k] : tg[k];
      hi[k]  = (cur[k] < tg[k]) ? tg[k] : cur[k];
    end
    while (cur[0] != tg[0] || cur[1] != tg[1] || cur[2] != tg[2] || cur[3] != tg[3]) begin
      for (int k = 0; k < 4; k++) begin
        diff = tg[k] - cur[k];
        if ((diff < 0 ? -diff : diff) <= seff) cur[k] = tg[k];
        else cur[k] = cur[k] + ((diff > 0) ? seff : -seff);
      end
      exp_q.push_back(pack4(cur[0], cur[1], cur[2], cur[3]));
    end
    n = exp_q.size();
    period = 3 + VC + d;
    repulse = repulse_in && (n >= 2);
    rises = 0; vcycles = 0; dones = 0; done_cyc = -1; idle_cyc = -1;
    prev_v = 1'b0; range_ok = 1'b1; ended = 1'b0;

    applyStimulus(1'b1, 1'b0, tv, 9'(s), 8'(d));
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (repulse && c == 8) begin
        start  = 1'b1;
        tgt_pi = ~tv;
        step   = 9'd1;
      end
      if (repulse && c == 9) start = 1'b0;
      if (ctl_valid) vcycles++;
      if (ctl_valid && !prev_v) begin
        if (rises < n)
          checkOutput($sformatf("%s code step %0d", tag, rises), 64'(ctl_pi), 64'(exp_q[rises]));
        checkOutput($sformatf("%s strobe cycle %0d", tag, rises), 64'(c), 64'(3 + rises*period));
        rises++;
      end
      prev_v = ctl_valid;
      if (done) begin
        dones++;
        done_cyc = c;
      end
      for (int k = 0; k < 4; k++) begin
        v = lane(ctl_pi, k);
        if (v < lo[k] || v > hi[k]) range_ok = 1'b0;
      end
      if (!busy) begin
        idle_cyc = c;
        ended = 1'b1;
        break;
      end
    end
    checkOutput({tag, " finished in bound"}, 64'(ended), 64'd1);
    checkOutput({tag, " strobe count"}, 64'(rises), 64'(n));
    checkOutput({tag, " valid cycles"}, 64'(vcycles), 64'(n*VC));
    checkOutput({tag, " done pulses"}, 64'(dones), 64'd1);
    checkOutput({tag, " done cycle"}, 64'(done_cyc), 64'(n*period + 1));
    checkOutput({tag, " idle cycle"}, 64'(idle_cyc), 64'(n*period + 2));
    checkOutput({tag, " final codes"}, 64'(ctl_pi), 64'(tv));
    checkOutput({tag, " range"}, 64'(range_ok), 64'd1);
    model_pi = tv;
  endtask

  initial begin
    logic [35:0] snap;
    logic [35:0] tv;
    bit changed, hit, seen_done;
    int rises, off, cur, t, s, d;
    bit prev;

    // Per-cycle table: abort-vs-start priority, a single-step ramp, then a no-op start.
    vecs[0] = '{1, 1, pack4(9,0,0,0), 4, 0, pack4(0,0,0,0), 0, 0, 0};
    vecs[1] = '{1, 0, pack4(3,0,0,0), 4, 0, pack4(0,0,0,0), 0, 1, 0};
    vecs[2] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 1, 0};
    vecs[3] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 1, 1, 0};
    vecs[4] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 1, 1, 0};
    vecs[5] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 1, 0};
    vecs[6] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 1, 1};
    vecs[7] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 0, 0};
    vecs[8] = '{1, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 1, 1};
    vecs[9] = '{0, 0, pack4(3,0,0,0), 4, 0, pack4(3,0,0,0), 0, 0, 0};

    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rstb = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset ctl_pi", 64'(ctl_pi), 64'd0);
    checkOutput("reset ctl_valid", 64'(ctl_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    rstb = 1'b1;
    model_pi = '0;
    changed = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ctl_pi !== '0 || ctl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) changed = 1'b1;
    end
    checkOutput("idle after reset stable", 64'(changed), 64'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].tgt, vecs[i].step, vecs[i].dwell);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("row%0d ctl_pi", i), 64'(ctl_pi), 64'(vecs[i].exp_pi));
      checkOutput($sformatf("row%0d ctl_valid", i), 64'(ctl_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      checkOutput($sformatf("row%0d done", i), 64'(done), 64'(vecs[i].exp_done));
    end
    model_pi = pack4(3,0,0,0);

    // Asynchronous reset in the middle of a ramp, away from any clock edge.
    applyStimulus(1'b1, 1'b0, pack4(50,50,50,50), 9'd4, 8'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    checkOutput("async reset ctl_pi", 64'(ctl_pi), 64'd0);
    checkOutput("async reset ctl_valid", 64'(ctl_valid), 64'd0);
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset done", 64'(done), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    model_pi = '0;

    runRamp(pack4(0,20,0,0), 31, 0, 1'b0, "preset");
    runRamp(pack4(10,5,0,0), 4, 0, 1'b0, "bidir");

    doReset();
    runRamp(pack4(2,0,0,0), 0, 5, 1'b0, "dwell");

    // Abort on the second strobe cycle of the third step.
    doReset();
    applyStimulus(1'b1, 1'b0, pack4(100,0,0,0), 9'd8, 8'd0);
    rises = 0; prev = 1'b0; hit = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (ctl_valid && !prev) rises++;
      prev = ctl_valid;
      if (rises == 3) begin
        @(negedge clk);
        checkOutput("abort second valid cycle", 64'(ctl_valid), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort ctl_valid", 64'(ctl_valid), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort ctl_pi", 64'(ctl_pi), 64'(pack4(24,0,0,0)));
        hit = 1'b1;
        break;
      end
    end
    checkOutput("abort reached step 3", 64'(hit), 64'd1);
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checkOutput("abort no done", 64'(seen_done), 64'd0);
    checkOutput("abort codes held", 64'(ctl_pi), 64'(pack4(24,0,0,0)));
    model_pi = pack4(24,0,0,0);

    // Abort on the first strobe cycle truncates the strobe.
    applyStimulus(1'b1, 1'b0, pack4(100,0,0,0), 9'd8, 8'd0);
    prev = 1'b0; hit = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (ctl_valid && !prev) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("truncate ctl_valid", 64'(ctl_valid), 64'd0);
        checkOutput("truncate ctl_pi", 64'(ctl_pi), 64'(pack4(32,0,0,0)));
        hit = 1'b1;
        break;
      end
      prev = ctl_valid;
    end
    checkOutput("truncate reached strobe", 64'(hit), 64'd1);
    model_pi = pack4(32,0,0,0);

    runRamp(pack4(72,30,0,10), 4, 1, 1'b1, "busy restart");
    runRamp(pack4(72,30,0,10), 4, 0, 1'b0, "noop");

    for (int it = 0; it < 30; it++) begin
      s = int'($urandom_range(0, 64));
      d = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        cur = lane(model_pi, k);
        off = int'($urandom_range(0, 16 * ((s == 0) ? 1 : s))) - 8 * ((s == 0) ? 1 : s);
        t = cur + off;
        if (t < 0) t = 0;
        if (t > 511) t = 511;
        tv[k*9 +: 9] = 9'(t);
      end
      runRamp(tv, s, d, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    snap = ctl_pi;
    checkOutput("final model agreement", 64'(snap), 64'(model_pi));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
